// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Decode-side interlock for the 5-stage pipeline. It freezes PC and the FD
// latch and injects a nop into DX for two cases: load-use dependencies and
// dependencies on an in-flight multi-cycle mul/div. A two-state FSM tracks
// the pending mul/div destination, and a counter bounds how long it waits.
//
// Optional feature macro: HAZARD_SW_BYPASS_EN
//   Defined   : a sw whose only dependency on a DX lw is its store data
//               does not stall, because the M-stage bypass covers it.
//   Undefined : any source match against a DX lw stalls one cycle.
module hazard_stall_unit #(
    parameter int MD_TIMEOUT = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fd_instruction,
    input  logic [31:0] dx_instruction,
    input  logic        multdiv_ready,
    output logic        stall,
    output logic        dx_bubble,
    output logic        md_start,
    output logic [4:0]  md_dest,
    output logic        md_busy,
    output logic        md_error
);

    localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    // Registered state
    logic [0:0]       state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [4:0]       dest_reg, dest_next;
    logic             error_reg, error_next;

    // Field decode
    logic [4:0] fd_op, fd_rd, fd_rs, fd_rt, fd_alu;
    logic [4:0] dx_op, dx_rd, dx_alu;

    assign fd_op  = fd_instruction[31:27];
    assign fd_rd  = fd_instruction[26:22];
    assign fd_rs  = fd_instruction[21:17];
    assign fd_rt  = fd_instruction[16:12];
    assign fd_alu = fd_instruction[6:2];
    assign dx_op  = dx_instruction[31:27];
    assign dx_rd  = dx_instruction[26:22];
    assign dx_alu = dx_instruction[6:2];

    // Immediate / shamt bits play no part in the interlock decision.
    logic unused_bits;
    assign unused_bits = ^{fd_instruction[11:7], fd_instruction[1:0],
                           dx_instruction[21:7], dx_instruction[1:0]};

    logic dx_is_lw, dx_is_md, fd_is_md, fd_is_sw;
    assign dx_is_lw = (dx_op == OP_LW) && (dx_rd != 5'd0);
    assign dx_is_md = (dx_op == OP_RTYPE) && ((dx_alu == ALU_MUL) || (dx_alu == ALU_DIV));
    assign fd_is_md = (fd_op == OP_RTYPE) && ((fd_alu == ALU_MUL) || (fd_alu == ALU_DIV));
    assign fd_is_sw = (fd_op == OP_SW);

    // FD source registers. Slot 0 is always the rs-style operand; slot 1
    // carries rt (R-type) or rd (sw data, branch compare, jr target).
    logic [4:0] fd_src [2];
    logic       fd_src_en [2];
    logic       fd_writes_rd;

    // Select which fields the FD instruction actually reads and writes
    always_comb begin
        fd_src[0]    = fd_rs;
        fd_src[1]    = fd_rd;
        fd_src_en[0] = 1'b0;
        fd_src_en[1] = 1'b0;
        fd_writes_rd = 1'b0;
        case (fd_op)
            OP_RTYPE: begin
                fd_src[1]    = fd_rt;
                fd_src_en[0] = 1'b1;
                fd_src_en[1] = 1'b1;
                fd_writes_rd = 1'b1;
            end
            OP_ADDI, OP_LW: begin
                fd_src_en[0] = 1'b1;
                fd_writes_rd = 1'b1;
            end
            OP_SW, OP_BNE, OP_BLT: begin
                fd_src_en[0] = 1'b1;
                fd_src_en[1] = 1'b1;
            end
            OP_JR: begin
                fd_src_en[1] = 1'b1;
            end
            default: begin
                fd_src_en[0] = 1'b0;
            end
        endcase
    end

    // Per-source comparisons against the DX load and the pending mul/div.
    // Register 0 is hard-wired, so it never matches.
    logic [1:0] lu_match;
    logic [1:0] md_match;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
            assign lu_match[gi] = fd_src_en[gi] && (fd_src[gi] != 5'd0) &&
                                  (fd_src[gi] == dx_rd);
            assign md_match[gi] = fd_src_en[gi] && (fd_src[gi] != 5'd0) &&
                                  (fd_src[gi] == dest_reg);
        end
    endgenerate

    logic load_use;
`ifdef HAZARD_SW_BYPASS_EN
    // Store data (slot 1 of a sw) is covered by the writeback->memory bypass.
    assign load_use = dx_is_lw && (lu_match[0] || (lu_match[1] && !fd_is_sw));
`else
    assign load_use = dx_is_lw && (lu_match[0] || lu_match[1]);
`endif

    logic fd_waw;
    logic md_hazard;
    assign fd_waw    = fd_writes_rd && (fd_rd != 5'd0) && (fd_rd == dest_reg);
    assign md_hazard = (state_reg == MD_BUSY) && !multdiv_ready &&
                       ((|md_match) || fd_waw || fd_is_md);

    assign stall     = !reset && (load_use || md_hazard);
    assign dx_bubble = stall;
    assign md_start  = !reset && (state_reg == IDLE) && dx_is_md;
    assign md_dest   = dest_reg;
    assign md_busy   = (state_reg == MD_BUSY);
    assign md_error  = error_reg;

    // FSM next-state: launch on a DX mul/div, wait for ready or timeout
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        dest_next  = dest_reg;
        error_next = error_reg;
        case (state_reg)
            IDLE: begin
                if (dx_is_md) begin
                    state_next = MD_BUSY;
                    count_next = '0;
                    dest_next  = dx_rd;
                end
            end
            MD_BUSY: begin
                if (multdiv_ready) begin
                    state_next = IDLE;
                end else if (count_reg == CNT_LAST) begin
                    state_next = IDLE;
                    error_next = 1'b1;
                end else begin
                    count_next = count_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            dest_reg  <= 5'd0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            dest_reg  <= dest_next;
            error_reg <= error_next;
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Testbench for hazard_stall_unit (built with MD_TIMEOUT=4). Table-driven
// IDLE-state vectors plus hand-written multi-cycle sequences; every step
// pushes its expected outputs to a scoreboard queue that the negedge
// monitor pops and compares.
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fd_i, dx_i;
    logic        rdy;
    logic        stall, dx_bubble, md_start, md_busy, md_error;
    logic [4:0]  md_dest;

    hazard_stall_unit #(.MD_TIMEOUT(4)) dut (
        .clock          (clk),
        .reset          (rst),
        .fd_instruction (fd_i),
        .dx_instruction (dx_i),
        .multdiv_ready  (rdy),
        .stall          (stall),
        .dx_bubble      (dx_bubble),
        .md_start       (md_start),
        .md_dest        (md_dest),
        .md_busy        (md_busy),
        .md_error       (md_error)
    );

    always #5 clk = ~clk;

`ifdef HAZARD_SW_BYPASS_EN
    localparam logic SW_DATA_STALL = 1'b0;
`else
    localparam logic SW_DATA_STALL = 1'b1;
`endif

    typedef struct {
        string       name;
        logic        chk_state;
        logic        e_stall;
        logic        e_start;
        logic        e_busy;
        logic [4:0]  e_dest;
        logic        e_err;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] fd;
        logic [31:0] dx;
        logic        e_stall;
    } vec_t;

    exp_t sb_q [$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rd, rs, rt, aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] op, rd, rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] add_i(input logic [4:0] rd, rs, rt);
        return rtype(rd, rs, rt, 5'b00000);
    endfunction

    function automatic logic [31:0] mul_i(input logic [4:0] rd, rs, rt);
        return rtype(rd, rs, rt, 5'b00110);
    endfunction

    function automatic logic [31:0] div_i(input logic [4:0] rd, rs, rt);
        return rtype(rd, rs, rt, 5'b00111);
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd);
        return itype(5'b01000, rd, 5'd2, 17'd4);
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Scoreboard consumer: compare DUT outputs mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check({e.name, ".stall"},     32'(stall),     32'(e.e_stall));
            check({e.name, ".dx_bubble"}, 32'(dx_bubble), 32'(e.e_stall));
            check({e.name, ".md_start"},  32'(md_start),  32'(e.e_start));
            if (e.chk_state) begin
                check({e.name, ".md_busy"},  32'(md_busy),  32'(e.e_busy));
                check({e.name, ".md_dest"},  32'(md_dest),  32'(e.e_dest));
                check({e.name, ".md_error"}, 32'(md_error), 32'(e.e_err));
            end
            $display("txn %s: stall=%0b bubble=%0b start=%0b busy=%0b dest=%0d err=%0b",
                     e.name, stall, dx_bubble, md_start, md_busy, md_dest, md_error);
        end
    end

    task automatic step(input string nm, input logic [31:0] fd, input logic [31:0] dx,
                        input logic r, input logic rs_, input logic chk,
                        input logic e_stall, input logic e_start, input logic e_busy,
                        input logic [4:0] e_dest, input logic e_err);
        exp_t e;
        @(posedge clk);
        #1;
        fd_i = fd;
        dx_i = dx;
        rdy  = r;
        rst  = rs_;
        e.name = nm; e.chk_state = chk; e.e_stall = e_stall; e.e_start = e_start;
        e.e_busy = e_busy; e.e_dest = e_dest; e.e_err = e_err;
        sb_q.push_back(e);
    endtask

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{"lu_rs",       add_i(4, 3, 5),                      lw_i(3), 1'b1};
        vecs[1]  = '{"lu_rt",       add_i(4, 5, 3),                      lw_i(3), 1'b1};
        vecs[2]  = '{"lu_none",     add_i(4, 5, 6),                      lw_i(3), 1'b0};
        vecs[3]  = '{"sw_data",     itype(5'b00111, 3, 6, 17'd0),        lw_i(3), SW_DATA_STALL};
        vecs[4]  = '{"sw_addr",     itype(5'b00111, 6, 3, 17'd0),        lw_i(3), 1'b1};
        vecs[5]  = '{"lw_r0",       add_i(1, 0, 0),                      lw_i(0), 1'b0};
        vecs[6]  = '{"addi_rs",     itype(5'b00101, 4, 3, 17'd5),        lw_i(3), 1'b1};
        vecs[7]  = '{"addi_imm",    itype(5'b00101, 4, 5, 17'h03000),    lw_i(3), 1'b0};
        vecs[8]  = '{"bne_rd",      itype(5'b00010, 3, 1, 17'd2),        lw_i(3), 1'b1};
        vecs[9]  = '{"blt_rs",      itype(5'b00110, 1, 3, 17'd2),        lw_i(3), 1'b1};
        vecs[10] = '{"jr_rd",       itype(5'b00100, 3, 0, 17'd0),        lw_i(3), 1'b1};
        vecs[11] = '{"j_nosrc",     itype(5'b00001, 3, 3, 17'd0),        lw_i(3), 1'b0};

        fd_i = '0; dx_i = '0; rdy = 1'b0; rst = 1'b1;

        // Reset: outputs forced low even with a mul in DX
        step("rst0", add_i(4, 3, 5), mul_i(7, 1, 2), 0, 1, 0, 0, 0, 0, 5'd0, 0);
        step("rst1", add_i(4, 3, 5), mul_i(7, 1, 2), 0, 1, 1, 0, 0, 0, 5'd0, 0);

        // IDLE-state load-use table
        foreach (vecs[i])
            step(vecs[i].name, vecs[i].fd, vecs[i].dx, 0, 0, 1, vecs[i].e_stall, 0, 0, 5'd0, 0);
        step("non_lw_dx", add_i(4, 3, 5), add_i(3, 1, 2), 0, 0, 1, 0, 0, 0, 5'd0, 0);

        // Load-use stall lasts one cycle; then DX holds the bubble
        step("lu1_a", add_i(4, 3, 5), lw_i(3), 0, 0, 1, 1, 0, 0, 5'd0, 0);
        step("lu1_b", add_i(4, 3, 5), 32'h0,   0, 0, 1, 0, 0, 0, 5'd0, 0);

        // mul r7: start, RAW/WAW/structural stalls, ready releases
        step("md0", 32'h0,          mul_i(7, 1, 2), 0, 0, 1, 0, 1, 0, 5'd0, 0);
        step("md1", add_i(8, 7, 1), lw_i(1),        0, 0, 1, 1, 0, 1, 5'd7, 0);
        step("md2", add_i(7, 1, 2), 32'h0,          0, 0, 1, 1, 0, 1, 5'd7, 0);
        step("md3", div_i(9, 1, 2), 32'h0,          0, 0, 1, 1, 0, 1, 5'd7, 0);
        step("md4", div_i(9, 1, 2), 32'h0,          1, 0, 1, 0, 0, 1, 5'd7, 0);
        step("md5", 32'h0,          div_i(9, 1, 2), 0, 0, 1, 0, 1, 0, 5'd7, 0);
        step("md6", add_i(10, 9, 1), 32'h0,         0, 0, 1, 1, 0, 1, 5'd9, 0);
        step("md7", add_i(10, 9, 1), 32'h0,         1, 0, 1, 0, 0, 1, 5'd9, 0);
        step("md8", 32'h0,          32'h0,          0, 0, 1, 0, 0, 0, 5'd9, 0);

        // Timeout after 4 busy cycles without ready
        step("to0", 32'h0, mul_i(5, 1, 2), 0, 0, 1, 0, 1, 0, 5'd9, 0);
        for (int k = 1; k <= 4; k++)
            step($sformatf("to%0d", k), 32'h0, 32'h0, 0, 0, 1, 0, 0, 1, 5'd5, 0);
        step("to5", 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 5'd5, 1);
        step("to6", 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 5'd5, 1);

        // mul r0: no data hazard on r0, structural still stalls; error sticky
        step("z0", 32'h0,          mul_i(0, 1, 2), 0, 0, 1, 0, 1, 0, 5'd5, 1);
        step("z1", add_i(1, 0, 0), 32'h0,          0, 0, 1, 0, 0, 1, 5'd0, 1);
        step("z2", add_i(9, 1, 2), 32'h0,          0, 0, 1, 0, 0, 1, 5'd0, 1);
        step("z3", div_i(9, 1, 2), 32'h0,          0, 0, 1, 1, 0, 1, 5'd0, 1);
        step("z4", 32'h0,          32'h0,          0, 0, 1, 0, 0, 1, 5'd0, 1);
        step("z5", 32'h0,          32'h0,          0, 0, 1, 0, 0, 0, 5'd0, 1);

        // Reset while busy clears everything on the next edge
        step("r0", 32'h0,          mul_i(9, 1, 2), 0, 0, 1, 0, 1, 0, 5'd0, 1);
        step("r1", div_i(9, 1, 2), 32'h0,          0, 0, 1, 1, 0, 1, 5'd9, 1);
        step("r2", div_i(9, 1, 2), mul_i(9, 1, 2), 0, 1, 1, 0, 0, 1, 5'd9, 1);
        step("r3", div_i(9, 1, 2), 32'h0,          0, 0, 1, 0, 0, 0, 5'd0, 0);
        step("r4", 32'h0,          mul_i(4, 1, 2), 0, 0, 1, 0, 1, 0, 5'd0, 0);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Decode-side interlock for the 5-stage pipeline: it decides when the FD latch and PC must freeze and a nop must be injected into DX. It handles two cases the bypass network cannot cover: load-use dependencies and dependencies on an in-flight multi-cycle mul/div. It tracks the pending mul/div destination with a small FSM and a timeout counter.

## Interface
Parameters:
- MD_TIMEOUT, 40, number of MD_BUSY cycles without multdiv_ready before md_error is raised.

Ports:
- clock  in  1  pipeline clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- fd_instruction  in  32  instruction in the FD latch (the consumer).
- dx_instruction  in  32  instruction in the DX latch (the producer).
- multdiv_ready  in  1  one-cycle pulse; the multdiv result is on the writeback path this cycle.
- stall  out  1  hold PC and FD latch.
- dx_bubble  out  1  load nop (32'h0) into DX next edge.
- md_start  out  1  one-cycle start pulse to the multdiv unit.
- md_dest  out  5  destination register of the pending mul/div.
- md_busy  out  1  mul/div in flight.
- md_error  out  1  sticky timeout flag.

## Operation
Field decode:
- opcode [31:27], rd [26:22], rs [21:17], rt [16:12], aluop [6:2].
- R-type is opcode 00000; mul is aluop 00110, div is aluop 00111.
- lw is 01000 and writes rd.

FD source registers:
- R-type: rs, rt.
- addi (00101) / lw: rs.
- sw (00111): rd (data) and rs (address).
- bne (00010) / blt (00110): rd, rs.
- jr (00100): rd.
- Other opcodes: none.
- Register 0 never creates a hazard.

Load-use hazard:
- Condition: DX is lw with rd≠0, and an FD source equals DX.rd.
- Exception: see HAZARD_SW_BYPASS_EN.

Multdiv hazard (FSM state MD_BUSY only, suppressed in any cycle where multdiv_ready=1):
- An FD source equals md_dest, or
- FD writes md_dest (WAW), or
- FD is itself mul/div (structural).

Outputs:
- stall = dx_bubble = load_use | md_hazard.

FSM states: IDLE, MD_BUSY.
- IDLE: when DX is mul/div, md_start=1 this cycle. Next edge: md_dest←DX.rd, counter←0, go to MD_BUSY. multdiv_ready is ignored in IDLE.
- MD_BUSY: md_busy=1; counter increments each cycle.
  - multdiv_ready=1 → IDLE next edge.
  - Else, counter reaches MD_TIMEOUT−1 → md_error←1, go to IDLE.
  - md_start is never asserted in MD_BUSY. A mul/div cannot reach DX there, because the structural stall blocks it.
- In the ready cycle, a mul/div in FD is not stalled. It enters DX next cycle while the FSM is IDLE, and md_start fires then.

## Timing
Reset values:
- state IDLE, counter 0, md_dest 0, md_busy 0, md_error 0.
- stall, dx_bubble and md_start are forced 0 while reset=1.

Output timing:
- stall, dx_bubble and md_start are combinational from the latches and registered state; there is no added latency.
- A load-use stall lasts exactly one cycle. The next cycle DX holds the bubble.
- md_busy rises the edge after md_start and falls the edge after multdiv_ready or timeout.

Boundary conditions:
- load_use and md_hazard in the same cycle: single stall, no double count.
- md_error stays set until reset; the unit keeps operating after a timeout.
- Reset in MD_BUSY: IDLE on the next edge, the pending destination is discarded, and the multdiv unit is reset by its own reset.

## Configuration
HAZARD_SW_BYPASS_EN:
- Defined: when DX is lw, FD is sw, and the only match is sw.rd (store data) = lw.rd, there is no stall. The data is forwarded writeback→memory by the M-stage bypass. A match on sw.rs still stalls.
- Undefined: any source match with a DX lw stalls one cycle, including sw data.

## Test plan
- DX lw r3; FD add r4,r3,r5 → stall=1 and dx_bubble=1 for exactly one cycle, then 0.
- DX lw r3; FD sw r3,0(r6) → stall=0 with HAZARD_SW_BYPASS_EN, stall=1 without. FD sw r6,0(r3) → stall=1 in both builds.
- DX mul r7,r1,r2 → md_start=1 for one cycle; next cycle md_busy=1, md_dest=7. FD add r8,r7,r1 holds stall=1 until the multdiv_ready cycle, where stall=0. md_busy=0 the following cycle.
- MD_TIMEOUT=4, no multdiv_ready → md_error=1 and md_busy=0 after 4 busy cycles; md_error stays 1 until reset.
- DX lw r0; FD add r1,r0,r0 → stall=0. In MD_BUSY with md_dest=0 (mul r0): FD reading r0 → no data stall, but FD div → stall=1.
- Reset asserted mid-MD_BUSY → next cycle md_busy=0, md_dest=0, md_error=0, stall=0.
